scramble_key_gen: RTL

- Generates the per-frame pair of 24-bit block-permutation keys (left half, right half) consumed by the FFT-bin reorder stage in the scramble sender.
- Each key encodes a permutation of 8 four-bin blocks: eight 3-bit source indices.
- Keys are computed in the background with an LFSR-driven Fisher-Yates shuffle, then double-buffered so they change only on a frame boundary.

---
 rtl/scramble_key_gen.sv | 154 +++++++++++++++
 1 files changed

// File: rtl/scramble_key_gen.sv
// Background generator of per-frame left/right block-permutation keys for the FFT-bin reorder.
// An LFSR-driven Fisher-Yates shuffle fills a pending pair that is swapped in on frame_start.
module scramble_key_gen #(
    parameter logic [15:0] SEED = 16'hACE1,
    parameter logic [15:0] POLY = 16'hB400
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        enable,
    input  logic        frame_start,
    input  logic        seed_load,
    input  logic [15:0] seed_in,
    output logic [23:0] current_key_l,
    output logic [23:0] current_key_r,
    output logic        key_valid,
    output logic        busy,
    output logic        overrun
);

    typedef enum logic [2:0] {
        StInitL, StShufL, StPackL, StInitR, StShufR, StPackR, StDone
    } state_t;

    state_t           state_q, state_d;
    logic [15:0]      lfsr_q, lfsr_d;
    logic [7:0][2:0]  perm_q, perm_d;
    logic [2:0]       idx_q, idx_d;
    logic [23:0]      pend_l_q, pend_l_d, pend_r_q, pend_r_d;
    logic             pend_valid_q, pend_valid_d;
    logic [23:0]      act_l_q, act_l_d, act_r_q, act_r_d;
    logic [23:0]      key_l_q, key_l_d, key_r_q, key_r_d;
    logic             key_valid_q, key_valid_d;
    logic             overrun_q, overrun_d;

    logic [11:0]      prod;
    logic [2:0]       swap_j;
    logic [23:0]      packed_key;
    logic             transfer;

    always_comb begin
        state_d      = state_q;
        lfsr_d       = lfsr_q;
        perm_d       = perm_q;
        idx_d        = idx_q;
        pend_l_d     = pend_l_q;
        pend_r_d     = pend_r_q;
        pend_valid_d = pend_valid_q;
        act_l_d      = act_l_q;
        act_r_d      = act_r_q;
        key_valid_d  = key_valid_q;

        // j = floor(lfsr[7:0] * (i+1) / 256) lies in 0..i
        prod   = {4'b0, lfsr_q[7:0]} * {8'b0, {1'b0, idx_q} + 4'd1};
        swap_j = prod[10:8];

        packed_key = '0;
        for (int k = 0; k < 8; k++) begin
            packed_key[23-3*k -: 3] = perm_q[k];
        end

        case (state_q)
            StInitL, StInitR: begin
                for (int k = 0; k < 8; k++) begin
                    perm_d[k] = 3'(k);
                end
                idx_d   = 3'd7;
                state_d = (state_q == StInitL) ? StShufL : StShufR;
            end
            StShufL, StShufR: begin
                perm_d[idx_q]  = perm_q[swap_j];
                perm_d[swap_j] = perm_q[idx_q];
                lfsr_d = (lfsr_q >> 1) ^ (lfsr_q[0] ? POLY : 16'h0000);
                idx_d  = idx_q - 3'd1;
                if (idx_q == 3'd1) begin
                    state_d = (state_q == StShufL) ? StPackL : StPackR;
                end
            end
            StPackL: begin
                pend_l_d = packed_key;
                state_d  = StInitR;
            end
            StPackR: begin
                pend_r_d     = packed_key;
                pend_valid_d = 1'b1;
                state_d      = StDone;
            end
            StDone: begin
                state_d = StDone;
            end
            default: begin
                state_d = StInitL;
            end
        endcase

        transfer  = frame_start && pend_valid_q;
        overrun_d = frame_start && !pend_valid_q;
        if (transfer) begin
            act_l_d      = pend_l_q;
            act_r_d      = pend_r_q;
            key_valid_d  = 1'b1;
            pend_valid_d = 1'b0;
            state_d      = StInitL;
        end

        // A seed load takes effect after any same-cycle transfer of the old pair
        if (seed_load) begin
            lfsr_d       = (seed_in == 16'h0000) ? SEED : seed_in;
            pend_valid_d = 1'b0;
            state_d      = StInitL;
        end

        key_l_d = enable ? act_l_d : 24'h000000;
        key_r_d = enable ? act_r_d : 24'h000000;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q      <= StInitL;
            lfsr_q       <= SEED;
            perm_q       <= '0;
            idx_q        <= 3'd7;
            pend_l_q     <= '0;
            pend_r_q     <= '0;
            pend_valid_q <= 1'b0;
            act_l_q      <= '0;
            act_r_q      <= '0;
            key_l_q      <= '0;
            key_r_q      <= '0;
            key_valid_q  <= 1'b0;
            overrun_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            lfsr_q       <= lfsr_d;
            perm_q       <= perm_d;
            idx_q        <= idx_d;
            pend_l_q     <= pend_l_d;
            pend_r_q     <= pend_r_d;
            pend_valid_q <= pend_valid_d;
            act_l_q      <= act_l_d;
            act_r_q      <= act_r_d;
            key_l_q      <= key_l_d;
            key_r_q      <= key_r_d;
            key_valid_q  <= key_valid_d;
            overrun_q    <= overrun_d;
        end
    end

    assign current_key_l = key_l_q;
    assign current_key_r = key_r_q;
    assign key_valid     = key_valid_q;
    assign overrun       = overrun_q;
    assign busy          = (state_q != StDone);

endmodule
